uart_parity_engine: RTL and testbench
=====================================

// Module: uart_parity_engine
// PURPOSE
//   Parametrised UART parity generator/checker. TX side: captures a parallel word, folds it
//   bit-serially over the programmed data length and presents a registered parity bit to
//   the serializer. RX side: accumulates deserialized bits, then checks the received parity bit.
//   Supports even/odd/mark/space modes with runtime data length. Sits between the UART
//   config registers and the TX serializer / RX deserializer.
// PARAMETERS
//   MAX_WIDTH   8                        maximum data bits per frame (>=2)
//   LEN_W       $clog2(MAX_WIDTH+1)      width of DATA_LEN; localparam, do not override
// PORTS
//   CLK          in   1          single clock, rising edge
//   RST          in   1          reset, synchronous, active-high
//   PAR_EN       in   1          1 = parity enabled; 0 = TX capture and RX check disabled
//   PAR_MODE     in   2          00 even, 01 odd, 10 mark (always 1), 11 space (always 0)
//   DATA_LEN     in   LEN_W      valid data bits, 1..MAX_WIDTH; 0 or >MAX_WIDTH => MAX_WIDTH
//   P_Data       in   MAX_WIDTH  TX parallel data, LSB first; bits >= DATA_LEN ignored
//   Data_Valid   in   1          TX data strobe
//   Busy         in   1          serializer busy; capture only when low
//   par_bit      out  1          TX parity bit, valid while par_valid=1
//   par_valid    out  1          TX parity ready; held until next capture
//   S_Start      in   1          RX frame start; clears RX accumulator
//   S_Bit        in   1          RX deserialized bit (data or parity)
//   S_Bit_Valid  in   1          S_Bit qualifier
//   Par_Chk_En   in   1          with S_Bit_Valid: S_Bit is the received parity bit
//   par_err      out  1          RX parity/length error; held until next S_Start
//   par_err_vld  out  1          one-cycle pulse when par_err updated
// BEHAVIOUR
//   Reset (RST=1 at edge): all outputs 0, TX FSM IDLE, counters/accumulators 0. Applies
//     mid-operation too; any in-flight word is discarded, no par_valid emitted.
//   TX FSM IDLE -> SHIFT -> DONE:
//     IDLE/DONE: Data_Valid & !Busy & PAR_EN => latch P_Data masked to len_eff, PAR_MODE,
//       len_eff; clear acc, cnt=0; par_valid<=0; go SHIFT. Otherwise hold state.
//     SHIFT: acc ^= data[cnt]; cnt++; when cnt==len_eff-1 go DONE.
//     DONE entry: par_bit <= even:acc, odd:~acc, mark:1, space:0; par_valid<=1.
//     Latency: capture at edge N => par_valid=1 after edge N+len_eff+1 (mark/space identical).
//     Data_Valid during SHIFT ignored (no queueing). Config changes after capture ignored.
//     PAR_EN=0: no capture; a held par_valid stays until next capture.
//   RX accumulator (independent of TX, uses live PAR_MODE/DATA_LEN):
//     S_Start: racc<=0, rcnt<=0, par_err<=0. Same-cycle S_Bit_Valid & !Par_Chk_En =>
//       result racc=S_Bit, rcnt=1 (start first, then bit).
//     S_Bit_Valid & !Par_Chk_En: racc^=S_Bit; rcnt++ saturating at MAX_WIDTH.
//     S_Bit_Valid & Par_Chk_En & PAR_EN: par_err <= (S_Bit != expected(racc,PAR_MODE))
//       | (rcnt != len_eff); par_err_vld pulses next cycle; racc/rcnt cleared.
//     PAR_EN=0: check ignored, par_err_vld never pulses.
//     S_Start with Par_Chk_En same cycle: start wins, check discarded.
// STRUCTURE
//   Shared package uart_pkg: PAR_MODE encodings (PAR_EVEN/ODD/MARK/SPACE), TX state
//     encodings, function len_eff(DATA_LEN, MAX_WIDTH), function expected_par(acc, mode).
//   Sub-module par_accum: serial XOR accumulator + saturating bit counter (clr, bit, vld);
//     instantiated once for TX and once for RX.
// TESTING
//   1 Reset mid-SHIFT: RST at 3rd shift cycle -> par_valid=0, par_bit=0, FSM IDLE; next word ok.
//   2 DATA_LEN=8, even, P_Data=8'hA5 -> par_bit=0, par_valid high 9 cycles after capture;
//     odd -> 1; mark -> 1; space -> 0.
//   3 DATA_LEN=7, even, P_Data=8'h80 -> bit7 masked, par_bit=0; DATA_LEN=0 treated as 8 -> 1.
//   4 Busy=1 or PAR_EN=0 with Data_Valid -> no capture; Data_Valid during SHIFT -> ignored,
//     result matches first word.
//   5 RX even, len 8: bits of 8'h07 then parity 1 -> par_err=0, par_err_vld 1-cycle pulse;
//     parity 0 -> par_err=1; only 7 data bits -> par_err=1 (length).
//   6 S_Start coincident with S_Bit_Valid=1, S_Bit=1 -> racc=1, rcnt=1; with Par_Chk_En ->
//     no par_err_vld.

Source files
------------

// File: rtl/uart_parity_engine_pkg.sv
// Shared definitions for the UART parity engine: parity mode and TX state encodings,
// plus the helpers that clamp the data length and turn an XOR fold into a parity bit.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_EVEN  = 2'b00,
    PAR_ODD   = 2'b01,
    PAR_MARK  = 2'b10,
    PAR_SPACE = 2'b11
  } par_mode_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_SHIFT = 2'd1,
    TX_DONE  = 2'd2
  } tx_state_t;

  // A zero or oversized length means "use the full word".
  function automatic int len_eff(input int data_len, input int max_width);
    if (data_len == 0 || data_len > max_width) begin
      return max_width;
    end
    return data_len;
  endfunction

  function automatic logic expected_par(input logic acc, input par_mode_t mode);
    case (mode)
      PAR_EVEN:  return acc;
      PAR_ODD:   return ~acc;
      PAR_MARK:  return 1'b1;
      PAR_SPACE: return 1'b0;
      default:   return acc;
    endcase
  endfunction

endpackage

// File: rtl/uart_parity_engine_par_accum.sv
// Serial XOR accumulator with a saturating bit counter, shared by the TX and RX paths.
// A clear and a valid bit in the same cycle load that bit as the first one of a new run.
module par_accum
  import uart_pkg::*;
#(
  parameter int MAX_WIDTH = 8,
  localparam int LEN_W = $clog2(MAX_WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic             s_bit,
  input  logic             vld,
  output logic             acc,
  output logic [LEN_W-1:0] cnt
);

  always_ff @(posedge CLK) begin
    if (RST) begin
      acc <= 1'b0;
      cnt <= '0;
    end else if (clr) begin
      acc <= vld & s_bit;
      cnt <= vld ? LEN_W'(1) : '0;
    end else if (vld) begin
      acc <= acc ^ s_bit;
      if (cnt != LEN_W'(MAX_WIDTH)) begin
        cnt <= cnt + LEN_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_parity_engine.sv
// UART parity generator/checker: TX folds a captured word bit-serially into a registered
// parity bit; RX folds deserialized bits and checks the received parity bit and frame length.
module uart_parity_engine
  import uart_pkg::*;
#(
  parameter int MAX_WIDTH = 8,
  localparam int LEN_W = $clog2(MAX_WIDTH + 1)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 PAR_EN,
  input  logic [1:0]           PAR_MODE,
  input  logic [LEN_W-1:0]     DATA_LEN,
  input  logic [MAX_WIDTH-1:0] P_Data,
  input  logic                 Data_Valid,
  input  logic                 Busy,
  output logic                 par_bit,
  output logic                 par_valid,
  input  logic                 S_Start,
  input  logic                 S_Bit,
  input  logic                 S_Bit_Valid,
  input  logic                 Par_Chk_En,
  output logic                 par_err,
  output logic                 par_err_vld
);

  tx_state_t            tx_state;
  tx_state_t            tx_next;
  logic [LEN_W-1:0]     len_live;
  logic [MAX_WIDTH-1:0] len_mask;
  logic [MAX_WIDTH-1:0] data_q;
  par_mode_t            mode_q;
  logic [LEN_W-1:0]     len_q;
  logic                 capture;
  logic                 tx_shift_vld;
  logic                 tx_load_par;
  logic                 tx_data_bit;
  logic                 tx_acc;
  logic [LEN_W-1:0]     tx_cnt;
  logic                 rx_chk;
  logic                 rx_clr;
  logic                 rx_vld;
  logic                 rx_acc;
  logic [LEN_W-1:0]     rx_cnt;

  assign len_live = LEN_W'(len_eff(int'(DATA_LEN), MAX_WIDTH));

  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      len_mask[i] = (i < int'(len_live));
    end
  end

  // A new word is only taken when the FSM is not busy folding the previous one.
  assign capture     = Data_Valid & ~Busy & PAR_EN & (tx_state != TX_SHIFT);
  assign tx_data_bit = |(data_q & (MAX_WIDTH'(1) << tx_cnt));

  always_ff @(posedge CLK) begin
    if (RST) begin
      tx_state <= TX_IDLE;
    end else begin
      tx_state <= tx_next;
    end
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE, TX_DONE: begin
        if (capture) begin
          tx_next = TX_SHIFT;
        end
      end
      TX_SHIFT: begin
        if (tx_cnt == len_q - LEN_W'(1)) begin
          tx_next = TX_DONE;
        end
      end
      default: tx_next = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_shift_vld = 1'b0;
    tx_load_par  = 1'b0;
    case (tx_state)
      TX_SHIFT: tx_shift_vld = 1'b1;
      TX_DONE:  tx_load_par  = ~capture;
      default: begin
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      data_q <= '0;
      mode_q <= PAR_EVEN;
      len_q  <= '0;
    end else if (capture) begin
      data_q <= P_Data & len_mask;
      mode_q <= par_mode_t'(PAR_MODE);
      len_q  <= len_live;
    end
  end

  // Reloading every DONE cycle is harmless: the accumulator is frozen outside SHIFT.
  always_ff @(posedge CLK) begin
    if (RST) begin
      par_bit   <= 1'b0;
      par_valid <= 1'b0;
    end else if (capture) begin
      par_valid <= 1'b0;
    end else if (tx_load_par) begin
      par_bit   <= expected_par(tx_acc, mode_q);
      par_valid <= 1'b1;
    end
  end

  par_accum #(.MAX_WIDTH(MAX_WIDTH)) u_tx_accum (
    .CLK   (CLK),
    .RST   (RST),
    .clr   (capture),
    .s_bit (tx_data_bit),
    .vld   (tx_shift_vld),
    .acc   (tx_acc),
    .cnt   (tx_cnt)
  );

  // A frame start outranks a parity check arriving in the same cycle.
  assign rx_chk = S_Bit_Valid & Par_Chk_En & PAR_EN & ~S_Start;
  assign rx_clr = S_Start | rx_chk;
  assign rx_vld = S_Bit_Valid & ~Par_Chk_En;

  par_accum #(.MAX_WIDTH(MAX_WIDTH)) u_rx_accum (
    .CLK   (CLK),
    .RST   (RST),
    .clr   (rx_clr),
    .s_bit (S_Bit),
    .vld   (rx_vld),
    .acc   (rx_acc),
    .cnt   (rx_cnt)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      par_err     <= 1'b0;
      par_err_vld <= 1'b0;
    end else begin
      par_err_vld <= rx_chk;
      if (S_Start) begin
        par_err <= 1'b0;
      end else if (rx_chk) begin
        par_err <= (S_Bit != expected_par(rx_acc, par_mode_t'(PAR_MODE))) |
                   (rx_cnt != len_live);
      end
    end
  end

endmodule

// File: tb/tb_uart_parity_engine.sv
// Scoreboard bench for uart_parity_engine: expected TX parity bits and RX error flags are
// queued as stimulus is driven and checked when par_valid rises or par_err_vld pulses.
module tb_uart_parity_engine;
  import uart_pkg::*;

  localparam int MAX_WIDTH = 8;
  localparam int LEN_W     = $clog2(MAX_WIDTH + 1);

  typedef struct {
    logic par;
    int   cap_cycle;
    int   len;
  } tx_exp_t;

  logic                 CLK = 1'b0;
  logic                 RST;
  logic                 PAR_EN;
  logic [1:0]           PAR_MODE;
  logic [LEN_W-1:0]     DATA_LEN;
  logic [MAX_WIDTH-1:0] P_Data;
  logic                 Data_Valid;
  logic                 Busy;
  logic                 par_bit;
  logic                 par_valid;
  logic                 S_Start;
  logic                 S_Bit;
  logic                 S_Bit_Valid;
  logic                 Par_Chk_En;
  logic                 par_err;
  logic                 par_err_vld;

  int      vectors     = 0;
  int      miscompares = 0;
  int      cycle       = 0;
  logic    last_par    = 1'b0;
  tx_exp_t tx_q[$];
  logic    rx_q[$];

  uart_parity_engine #(.MAX_WIDTH(MAX_WIDTH)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .PAR_EN      (PAR_EN),
    .PAR_MODE    (PAR_MODE),
    .DATA_LEN    (DATA_LEN),
    .P_Data      (P_Data),
    .Data_Valid  (Data_Valid),
    .Busy        (Busy),
    .par_bit     (par_bit),
    .par_valid   (par_valid),
    .S_Start     (S_Start),
    .S_Bit       (S_Bit),
    .S_Bit_Valid (S_Bit_Valid),
    .Par_Chk_En  (Par_Chk_En),
    .par_err     (par_err),
    .par_err_vld (par_err_vld)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, observed, expected, cycle);
    end
  endtask

  function automatic int effLen(input int dl);
    return (dl == 0 || dl > MAX_WIDTH) ? MAX_WIDTH : dl;
  endfunction

  function automatic logic refPar(input logic [MAX_WIDTH-1:0] d, input int len,
                                  input logic [1:0] mode);
    int ones = 0;
    for (int i = 0; i < len; i++) ones += int'(d[i]);
    case (mode)
      2'b00:   return logic'(ones % 2);
      2'b01:   return logic'((ones + 1) % 2);
      2'b10:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: compare on the falling edge, away from the DUT's active edge.
  logic prev_valid   = 1'b0;
  logic prev_err_vld = 1'b0;
  always @(negedge CLK) begin : monitor
    tx_exp_t e;
    logic    r;
    if (par_valid && !prev_valid) begin
      if (tx_q.size() == 0) begin
        checkOutput("tx_unexpected_valid", {31'd0, par_valid}, 32'd0);
      end else begin
        e = tx_q.pop_front();
        checkOutput("tx_par_bit", {31'd0, par_bit}, {31'd0, e.par});
        checkOutput("tx_latency", cycle - e.cap_cycle, e.len + 1);
      end
    end
    if (par_err_vld) begin
      checkOutput("rx_vld_pulse_len", {31'd0, prev_err_vld}, 32'd0);
      if (rx_q.size() == 0) begin
        checkOutput("rx_unexpected_vld", {31'd0, par_err_vld}, 32'd0);
      end else begin
        r = rx_q.pop_front();
        checkOutput("rx_par_err", {31'd0, par_err}, {31'd0, r});
      end
    end
    prev_valid   = par_valid;
    prev_err_vld = par_err_vld;
  end

  task automatic applyStimulus(input logic [MAX_WIDTH-1:0] data, input logic [LEN_W-1:0] dlen,
                               input logic [1:0] mode, input logic expect_capture);
    tx_exp_t e;
    P_Data     = data;
    DATA_LEN   = dlen;
    PAR_MODE   = mode;
    Data_Valid = 1'b1;
    tick();
    Data_Valid = 1'b0;
    if (expect_capture) begin
      e.par       = refPar(data, effLen(int'(dlen)), mode);
      e.cap_cycle = cycle;
      e.len       = effLen(int'(dlen));
      last_par    = e.par;
      tx_q.push_back(e);
    end
  endtask

  task automatic waitTxDrain();
    int budget = 40;
    while (tx_q.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    if (tx_q.size() != 0) begin
      checkOutput("tx_timeout", tx_q.size(), 0);
      tx_q.delete();
    end
  endtask

  task automatic waitRxDrain();
    int budget = 10;
    while (rx_q.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    if (rx_q.size() != 0) begin
      checkOutput("rx_timeout", rx_q.size(), 0);
      rx_q.delete();
    end
  endtask

  task automatic rxFrame(input logic [MAX_WIDTH-1:0] data, input int nbits,
                         input logic parity, input logic exp_err);
    S_Start = 1'b1;
    tick();
    S_Start = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      S_Bit       = data[i];
      S_Bit_Valid = 1'b1;
      tick();
    end
    S_Bit      = parity;
    Par_Chk_En = 1'b1;
    S_Bit_Valid = 1'b1;
    rx_q.push_back(exp_err);
    tick();
    S_Bit_Valid = 1'b0;
    Par_Chk_En  = 1'b0;
    S_Bit       = 1'b0;
    waitRxDrain();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RST = 1'b1; PAR_EN = 1'b1; PAR_MODE = 2'b00; DATA_LEN = LEN_W'(8);
    P_Data = '0; Data_Valid = 1'b0; Busy = 1'b0;
    S_Start = 1'b0; S_Bit = 1'b0; S_Bit_Valid = 1'b0; Par_Chk_En = 1'b0;
    tick();
    tick();
    checkOutput("rst_par_bit", {31'd0, par_bit}, 32'd0);
    checkOutput("rst_par_valid", {31'd0, par_valid}, 32'd0);
    checkOutput("rst_par_err", {31'd0, par_err}, 32'd0);
    checkOutput("rst_par_err_vld", {31'd0, par_err_vld}, 32'd0);
    checkOutput("rst_tx_state", {30'd0, dut.tx_state}, {30'd0, TX_IDLE});
    RST = 1'b0;
    tick();

    $display("[TB] TX: 8'hA5, length 8, all four modes");
    for (int m = 0; m < 4; m++) begin
      applyStimulus(8'hA5, LEN_W'(8), 2'(m), 1'b1);
      waitTxDrain();
    end
    repeat (3) tick();
    checkOutput("tx_hold_valid", {31'd0, par_valid}, 32'd1);

    $display("[TB] TX: length masking and clamping");
    applyStimulus(8'h80, LEN_W'(7), 2'b00, 1'b1);
    waitTxDrain();
    applyStimulus(8'h80, LEN_W'(0), 2'b00, 1'b1);
    waitTxDrain();
    applyStimulus(8'h03, LEN_W'(1), 2'b01, 1'b1);
    waitTxDrain();
    applyStimulus(8'h81, LEN_W'(15), 2'b01, 1'b1);
    waitTxDrain();

    $display("[TB] TX: config change after capture");
    applyStimulus(8'h01, LEN_W'(8), 2'b00, 1'b1);
    PAR_MODE = 2'b01;
    DATA_LEN = LEN_W'(3);
    waitTxDrain();

    $display("[TB] TX: Busy / PAR_EN blocking and Data_Valid during SHIFT");
    Busy = 1'b1;
    applyStimulus(8'hFE, LEN_W'(8), 2'b00, 1'b0);
    Busy = 1'b0;
    repeat (12) tick();
    checkOutput("busy_hold_valid", {31'd0, par_valid}, 32'd1);
    checkOutput("busy_hold_bit", {31'd0, par_bit}, {31'd0, last_par});
    PAR_EN = 1'b0;
    applyStimulus(8'hFE, LEN_W'(8), 2'b00, 1'b0);
    repeat (12) tick();
    PAR_EN = 1'b1;
    checkOutput("paren_hold_valid", {31'd0, par_valid}, 32'd1);
    applyStimulus(8'h01, LEN_W'(8), 2'b00, 1'b1);
    tick();
    applyStimulus(8'h03, LEN_W'(8), 2'b00, 1'b0);
    waitTxDrain();
    repeat (12) tick();
    checkOutput("shift_ignore_bit", {31'd0, par_bit}, 32'd1);

    $display("[TB] TX: reset during SHIFT");
    applyStimulus(8'h55, LEN_W'(8), 2'b00, 1'b0);
    tick();
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checkOutput("midrst_par_valid", {31'd0, par_valid}, 32'd0);
    checkOutput("midrst_par_bit", {31'd0, par_bit}, 32'd0);
    checkOutput("midrst_tx_state", {30'd0, dut.tx_state}, {30'd0, TX_IDLE});
    repeat (12) tick();
    applyStimulus(8'hA5, LEN_W'(8), 2'b01, 1'b1);
    waitTxDrain();

    $display("[TB] RX: frame checks");
    PAR_MODE = 2'b00;
    DATA_LEN = LEN_W'(8);
    rxFrame(8'h07, 8, 1'b1, 1'b0);
    rxFrame(8'h07, 8, 1'b0, 1'b1);
    rxFrame(8'h07, 7, 1'b1, 1'b1);
    repeat (2) tick();
    checkOutput("rx_err_hold", {31'd0, par_err}, 32'd1);
    S_Start = 1'b1;
    tick();
    S_Start = 1'b0;
    checkOutput("rx_start_clears", {31'd0, par_err}, 32'd0);
    PAR_MODE = 2'b01;
    rxFrame(8'h07, 8, 1'b0, 1'b0);
    PAR_MODE = 2'b10;
    rxFrame(8'h3C, 8, 1'b0, 1'b1);

    $display("[TB] RX: start coincident with bit / check");
    PAR_MODE = 2'b00;
    DATA_LEN = LEN_W'(1);
    S_Start = 1'b1; S_Bit = 1'b1; S_Bit_Valid = 1'b1;
    tick();
    S_Start = 1'b0; S_Bit_Valid = 1'b0;
    checkOutput("rx_start_bit_acc", {31'd0, dut.u_rx_accum.acc}, 32'd1);
    checkOutput("rx_start_bit_cnt", {28'd0, dut.u_rx_accum.cnt}, 32'd1);
    S_Bit = 1'b1; S_Bit_Valid = 1'b1; Par_Chk_En = 1'b1;
    rx_q.push_back(1'b0);
    tick();
    S_Bit_Valid = 1'b0; Par_Chk_En = 1'b0;
    waitRxDrain();
    S_Start = 1'b1; S_Bit = 1'b0; S_Bit_Valid = 1'b1; Par_Chk_En = 1'b1;
    tick();
    S_Start = 1'b0; S_Bit_Valid = 1'b0; Par_Chk_En = 1'b0;
    repeat (4) tick();
    checkOutput("rx_start_wins_err", {31'd0, par_err}, 32'd0);
    PAR_EN = 1'b0;
    S_Bit = 1'b0; S_Bit_Valid = 1'b1; Par_Chk_En = 1'b1;
    tick();
    S_Bit_Valid = 1'b0; Par_Chk_En = 1'b0;
    repeat (4) tick();
    PAR_EN = 1'b1;
    checkOutput("rx_paren_off_err", {31'd0, par_err}, 32'd0);
    checkOutput("tx_queue_empty", tx_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
